// File: rtl/spec_free_list_param_pkg.sv
// rtl/spec_free_list_param_pkg.sv - shared helpers for the speculative free list (package spec_free_list_pkg)
package spec_free_list_pkg;

    // Upper bound on dispatch/commit lanes; popcount works on this width.
    localparam int MAX_LANES = 8;

    // Ceiling log2, never less than 1 so a pointer always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // (a + b) mod depth for a, b < depth; a conditional subtract keeps non-power-of-two depths legal.
    function automatic int wrap_add(input int a, input int b, input int depth);
        int sum;
        sum = a + b;
        if (sum >= depth) sum = sum - depth;
        return sum;
    endfunction

    // (a - b) mod depth for a, b < depth.
    function automatic int wrap_sub(input int a, input int b, input int depth);
        int diff;
        diff = a - b;
        if (diff < 0) diff = diff + depth;
        return diff;
    endfunction

    // Number of set bits in a lane mask (narrower masks are zero-extended by the caller).
    function automatic int popcount(input logic [MAX_LANES-1:0] mask);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            ones = ones + int'(mask[i]);
        end
        return ones;
    endfunction

endpackage

// File: rtl/spec_free_list_param_if.sv
// rtl/spec_free_list_param_if.sv - rename-side allocation and commit-side release bundle
interface spec_free_list_param_if #(
    parameter int DISPATCH_W = 4,
    parameter int COMMIT_W   = 4,
    parameter int PHYS_LOG   = 6
);
    logic [DISPATCH_W-1:0]              req_i;
    logic [COMMIT_W-1:0]                commit_valid_i;
    logic [COMMIT_W*PHYS_LOG-1:0]       commit_reg_i;
    logic [DISPATCH_W*(PHYS_LOG+1)-1:0] free_reg_o;
    logic                               empty_o;

    modport master (
        output req_i, commit_valid_i, commit_reg_i,
        input  free_reg_o, empty_o
    );

    modport slave (
        input  req_i, commit_valid_i, commit_reg_i,
        output free_reg_o, empty_o
    );
endinterface

// File: rtl/spec_free_list_param_ram.sv
// rtl/spec_free_list_param_ram.sv - free-list storage: combinational read lanes, compacted write ports
module free_list_ram
    import spec_free_list_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int PHYS_LOG   = 6,
    parameter int NUM_ARCH   = 32,
    parameter int DISPATCH_W = 4,
    parameter int COMMIT_W   = 4,
    parameter int PTR_W      = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DISPATCH_W*PTR_W-1:0]    rdAddr,
    output logic [DISPATCH_W*PHYS_LOG-1:0] rdData,
    input  logic [COMMIT_W-1:0]            wrEn,
    input  logic [COMMIT_W*PTR_W-1:0]      wrAddr,
    input  logic [COMMIT_W*PHYS_LOG-1:0]   wrData
);
    logic [PHYS_LOG-1:0] mem [DEPTH];

    // Reset loads the identity-after-architectural tags; otherwise each write port stores its tag (addresses are distinct).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PHYS_LOG'(NUM_ARCH + i);
            end
        end else begin
            for (int j = 0; j < COMMIT_W; j++) begin
                if (wrEn[j]) mem[wrAddr[j*PTR_W +: PTR_W]] <= wrData[j*PHYS_LOG +: PHYS_LOG];
            end
        end
    end

    // Read lanes see only committed contents; no bypass from this cycle's writes.
    always_comb begin
        rdData = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            rdData[k*PHYS_LOG +: PHYS_LOG] = mem[rdAddr[k*PTR_W +: PTR_W]];
        end
    end
endmodule

// File: rtl/spec_free_list_param.sv
// rtl/spec_free_list_param.sv - parametrised speculative free list; SPEC_FREE_LIST_PARTIAL_ALLOC_EN enables per-lane allocation
module spec_free_list_param
    import spec_free_list_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int PHYS_LOG   = 6,
    parameter int NUM_ARCH   = 32,
    parameter int DISPATCH_W = 4,
    parameter int COMMIT_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_i,
    input  logic                      recover_i,
    input  logic                      br_recover_i,
    input  logic [clog2(DEPTH)-1:0]   head_cp_i,
    spec_free_list_param_if.slave     fl,
    output logic [clog2(DEPTH)-1:0]   head_o,
    output logic [clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]               head;
    logic [PTR_W-1:0]               tail;
    logic [PTR_W-1:0]               tailNext;
    logic [CNT_W-1:0]               count;
    logic [CNT_W-1:0]               brCount;
    logic                           empty;
    logic [DISPATCH_W-1:0]          laneValid;
    logic [DISPATCH_W-1:0]          grant;
    int                             pop;
    int                             push;
    int                             nextCount;
    logic [DISPATCH_W*PTR_W-1:0]    rdAddr;
    logic [DISPATCH_W*PHYS_LOG-1:0] rdData;
    logic [COMMIT_W*PTR_W-1:0]      wrAddr;

    free_list_ram #(
        .DEPTH(DEPTH), .PHYS_LOG(PHYS_LOG), .NUM_ARCH(NUM_ARCH),
        .DISPATCH_W(DISPATCH_W), .COMMIT_W(COMMIT_W), .PTR_W(PTR_W)
    ) ram (
        .clk(clk), .reset(reset),
        .rdAddr(rdAddr), .rdData(rdData),
        .wrEn(fl.commit_valid_i), .wrAddr(wrAddr), .wrData(fl.commit_reg_i)
    );

    // Allocation side: lane k looks at head+k; the block/valid rule depends on the allocation mode.
    always_comb begin
        rdAddr    = '0;
        laneValid = '0;
`ifdef SPEC_FREE_LIST_PARTIAL_ALLOC_EN
        empty = popcount(MAX_LANES'(fl.req_i)) > int'(count);
        for (int k = 0; k < DISPATCH_W; k++) begin
            laneValid[k] = int'(count) > k;
        end
`else
        empty     = int'(count) < DISPATCH_W;
        laneValid = {DISPATCH_W{!empty}};
`endif
        for (int k = 0; k < DISPATCH_W; k++) begin
            rdAddr[k*PTR_W +: PTR_W] = PTR_W'(wrap_add(int'(head), k, DEPTH));
        end
        grant = fl.req_i & {DISPATCH_W{!empty && !stall_i}};
        pop   = popcount(MAX_LANES'(grant));
    end

    // Per-lane {tag, valid} output, valid in the LSB.
    always_comb begin
        fl.free_reg_o = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            fl.free_reg_o[k*(PHYS_LOG+1) +: PHYS_LOG+1] = {rdData[k*PHYS_LOG +: PHYS_LOG], laneValid[k]};
        end
        fl.empty_o = empty;
    end

    // Push compaction: a running prefix count of valid release lanes picks each lane's slot past the tail.
    always_comb begin
        wrAddr = '0;
        push   = 0;
        for (int j = 0; j < COMMIT_W; j++) begin
            wrAddr[j*PTR_W +: PTR_W] = PTR_W'(wrap_add(int'(tail), push, DEPTH));
            push = push + int'(fl.commit_valid_i[j]);
        end
    end

    // Next tail, branch-recovery occupancy (0 means a completely full list) and the normal-path occupancy.
    always_comb begin
        tailNext = PTR_W'(wrap_add(int'(tail), push, DEPTH));
        brCount  = CNT_W'(wrap_sub(int'(tailNext), int'(head_cp_i), DEPTH));
        if (brCount == '0) brCount = CNT_W'(DEPTH);
        if (stall_i || empty) nextCount = int'(count) + push;
        else                  nextCount = int'(count) - pop + push;
    end

    // Pointer/occupancy update: reset, then full flush, then branch restore, then normal allocate/release.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
        end else begin
            tail <= tailNext;
            if (recover_i) begin
                head  <= tailNext;
                count <= CNT_W'(DEPTH);
            end else if (br_recover_i) begin
                head  <= head_cp_i;
                count <= brCount;
            end else begin
                if (!(stall_i || empty)) head <= PTR_W'(wrap_add(int'(head), pop, DEPTH));
                count <= CNT_W'(nextCount);
            end
        end
    end

    // Illegal-use checks: requests must fill lanes from 0 upward, and releases must never overfill the list.
    always @(posedge clk) begin
        if (!reset) begin
            assert ((int'(fl.req_i) & (int'(fl.req_i) + 1)) == 0);
            if (!recover_i && !br_recover_i) assert (nextCount <= DEPTH);
        end
    end

    assign head_o  = head;
    assign count_o = count;
endmodule

// File: tb/tb_spec_free_list_param.sv
// tb/tb_spec_free_list_param.sv - scoreboard bench for spec_free_list_param (DEPTH 32, 4 lanes each way)
module tb_spec_free_list_param;
    logic       clk;
    logic       reset;
    logic       stall;
    logic       rec;
    logic       br;
    logic [4:0] headCp;
    logic [4:0] headO;
    logic [5:0] countO;
    int         cyc;
    int         nPass;
    int         nTotal;

    typedef struct {
        int          cyc;
        string       name;
        int          head;
        int          count;
        logic [3:0]  req;
        logic [23:0] tags;
    } exp_t;

    exp_t q[$];
    exp_t e;

    spec_free_list_param_if #(.DISPATCH_W(4), .COMMIT_W(4), .PHYS_LOG(6)) flIf ();

    spec_free_list_param #(
        .DEPTH(32), .PHYS_LOG(6), .NUM_ARCH(32), .DISPATCH_W(4), .COMMIT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .stall_i(stall), .recover_i(rec),
        .br_recover_i(br), .head_cp_i(headCp), .fl(flIf.slave),
        .head_o(headO), .count_o(countO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic int ones(input logic [3:0] r);
        return int'(r[0]) + int'(r[1]) + int'(r[2]) + int'(r[3]);
    endfunction

    function automatic logic expEmpty(input int c, input logic [3:0] r);
`ifdef SPEC_FREE_LIST_PARTIAL_ALLOC_EN
        return ones(r) > c;
`else
        return c < 4;
`endif
    endfunction

    function automatic logic [3:0] expValid(input int c, input logic [3:0] r);
`ifdef SPEC_FREE_LIST_PARTIAL_ALLOC_EN
        return {c > 3, c > 2, c > 1, c > 0};
`else
        return {4{!expEmpty(c, r)}};
`endif
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        nTotal = nTotal + 1;
        if (act == exp) nPass = nPass + 1;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endfunction

    // Monitor: compare the DUT outputs against the expectation queued for this cycle.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk({e.name, " missed"}, cyc, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk({e.name, " head"}, int'(headO), e.head);
            chk({e.name, " count"}, int'(countO), e.count);
            chk({e.name, " empty"}, int'(flIf.empty_o), int'(expEmpty(e.count, e.req)));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("%s lane%0d tag", e.name, k), int'(flIf.free_reg_o[k*7+1 +: 6]), int'(e.tags[k*6 +: 6]));
                chk($sformatf("%s lane%0d valid", e.name, k), int'(flIf.free_reg_o[k*7]), int'(expValid(e.count, e.req)[k]));
            end
        end
    end

    task automatic drive(input logic rst, input logic [3:0] rq, input logic st, input logic rc,
                         input logic brv, input int cp, input logic [3:0] cv, input logic [23:0] cr,
                         input logic doChk, input string nm, input int eh, input int ec, input logic [23:0] et);
        @(posedge clk);
        #1;
        reset                = rst;
        flIf.req_i           = rq;
        stall                = st;
        rec                  = rc;
        br                   = brv;
        headCp               = 5'(cp);
        flIf.commit_valid_i  = cv;
        flIf.commit_reg_i    = cr;
        if (doChk) q.push_back('{cyc, nm, eh, ec, rq, et});
    endtask

    task automatic popOnly(input int n);
        for (int i = 0; i < n; i++) drive(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 24'd0, 0, "", 0, 0, 24'd0);
    endtask

    initial begin
        cyc = 0; nPass = 0; nTotal = 0;
        reset = 1'b1; stall = 1'b0; rec = 1'b0; br = 1'b0; headCp = '0;
        flIf.req_i = '0; flIf.commit_valid_i = '0; flIf.commit_reg_i = '0;

        drive(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 24'd0, 0, "", 0, 0, 24'd0);
        drive(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 24'd0, 0, "", 0, 0, 24'd0);
        drive(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "reset", 0, 32, pk(32, 33, 34, 35));
        drive(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "alloc0", 0, 32, pk(32, 33, 34, 35));
        drive(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "alloc1", 4, 28, pk(36, 37, 38, 39));
        drive(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "after_alloc", 8, 24, pk(40, 41, 42, 43));
        popOnly(5);
        drive(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "count4", 28, 4, pk(60, 61, 62, 63));
        drive(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "count3_req2", 29, 3, pk(61, 62, 63, 32));
`ifdef SPEC_FREE_LIST_PARTIAL_ALLOC_EN
        drive(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "after_req2", 31, 1, pk(63, 32, 33, 34));
`else
        drive(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "after_req2", 29, 3, pk(61, 62, 63, 32));
`endif
        drive(0, 4'b0000, 0, 1, 0, 0, 4'b0000, 24'd0, 0, "", 0, 0, 24'd0);
        drive(0, 4'b1111, 1, 0, 0, 0, 4'b0000, 24'd0, 1, "stall", 0, 32, pk(32, 33, 34, 35));
        drive(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "post_stall", 0, 32, pk(32, 33, 34, 35));
        drive(0, 4'b0000, 0, 0, 0, 0, 4'b1010, pk(7, 5, 11, 9), 1, "push1010", 4, 28, pk(36, 37, 38, 39));
        drive(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "post_push", 4, 30, pk(36, 37, 38, 39));
        popOnly(5);
        drive(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "head28", 28, 6, pk(60, 61, 62, 63));
        drive(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "wrap30", 30, 4, pk(62, 63, 5, 9));
        drive(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "count0", 2, 0, pk(34, 35, 36, 37));
        drive(0, 4'b0000, 0, 0, 0, 0, 4'b1111, pk(40, 41, 42, 43), 1, "push4", 2, 0, pk(34, 35, 36, 37));
        drive(0, 4'b0000, 0, 0, 1, 10, 4'b0011, pk(44, 45, 0, 0), 1, "br_push2", 2, 4, pk(40, 41, 42, 43));
        drive(0, 4'b0000, 0, 0, 0, 0, 4'b0011, pk(46, 47, 0, 0), 1, "after_br", 10, 30, pk(42, 43, 44, 45));
        drive(0, 4'b0000, 0, 0, 1, 10, 4'b0000, 24'd0, 1, "br_push0", 10, 32, pk(42, 43, 44, 45));
        drive(0, 4'b1111, 0, 0, 0, 0, 4'b1111, pk(20, 21, 22, 23), 1, "after_br0", 10, 32, pk(42, 43, 44, 45));
        drive(0, 4'b1111, 0, 0, 0, 0, 4'b1111, pk(24, 25, 26, 27), 1, "pop_push", 14, 32, pk(46, 47, 48, 49));
        drive(0, 4'b1111, 0, 0, 0, 0, 4'b0011, pk(28, 29, 0, 0), 0, "", 0, 0, 24'd0);
        drive(0, 4'b0000, 0, 1, 1, 5, 4'b0001, pk(50, 0, 0, 0), 1, "rec_and_br", 22, 30, pk(54, 55, 56, 57));
        drive(0, 4'b0001, 0, 0, 0, 0, 4'b0001, pk(55, 0, 0, 0), 1, "after_rec", 21, 32, pk(53, 54, 55, 56));
        drive(0, 4'b0000, 0, 0, 1, 21, 4'b0000, 24'd0, 1, "tail_probe", 22, 32, pk(54, 55, 56, 57));
        drive(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "tail22", 21, 1, pk(55, 54, 55, 56));
        drive(1, 4'b1111, 0, 0, 0, 0, 4'b1111, pk(1, 2, 3, 4), 0, "", 0, 0, 24'd0);
        drive(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 24'd0, 1, "mid_reset", 0, 32, pk(32, 33, 34, 35));
        drive(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 24'd0, 0, "", 0, 0, 24'd0);
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end
endmodule

// File: doc/spec_free_list_param.md
Name: spec_free_list_param

Overview:
Parametrised speculative physical-register free list for the rename stage. It supplies up to DISPATCH_W free physical tags per cycle and accepts up to COMMIT_W released tags per cycle, packing them contiguously at the tail. It supports full-flush recovery and branch-checkpoint head restore. It replaces the fixed 4-wide free list, generalising depth, dispatch width and commit width, and adds a live occupancy output and an optional partial-allocation mode.

Parameters:
DEPTH, 32, number of free-list entries; power of two not required.
PHYS_LOG, 6, physical register tag width.
NUM_ARCH, 32, architectural registers; entry i resets to tag NUM_ARCH+i.
DISPATCH_W, 4, allocation lanes per cycle (1..8).
COMMIT_W, 4, release lanes per cycle (1..8).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
stall_i  in  1  rename stall; no pops this cycle
recover_i  in  1  full pipeline flush
br_recover_i  in  1  branch mispredict recovery using head_cp_i
head_cp_i  in  clog2(DEPTH)  checkpointed head
req_i  in  DISPATCH_W  per-lane allocation request
commit_valid_i  in  COMMIT_W  per-lane release valid
commit_reg_i  in  COMMIT_W*PHYS_LOG  released tags, lane 0 in LSBs
head_o  out  clog2(DEPTH)  current head, for checkpointing
free_reg_o  out  DISPATCH_W*(PHYS_LOG+1)  per lane {tag, valid}; valid is the LSB
empty_o  out  1  allocation blocked this cycle
count_o  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset values: head=0, tail=0 (mod DEPTH), count=DEPTH, RAM[i]=NUM_ARCH+i, empty_o=0, head_o=0, count_o=DEPTH.
- Reads are combinational. Lane k presents RAM[(head+k) mod DEPTH]. Valid bit = !empty_o, regardless of req_i.
- Default mode: empty_o = (count < DISPATCH_W).
- Granted lanes: grant[k] = req_i[k] & !empty_o & !stall_i. pop = popcount(grant).
- Lanes are not compacted on the pop side. Rename requests lanes contiguously from lane 0. A non-contiguous req_i is illegal.
- Pushes are compacted. The j-th set bit of commit_valid_i writes its tag to RAM[(tail+j) mod DEPTH]. push = popcount(commit_valid_i).
- Writes commit at the posedge. A tag written at cycle N is readable at cycle N+1. There is no same-cycle bypass.
- Tail: tail <= (tail+push) mod DEPTH every non-reset cycle, including either recovery.
- Head/count update priority, one per cycle:
  - reset: as above.
  - recover_i: head <= (tail+push) mod DEPTH; count <= DEPTH.
  - br_recover_i: head <= head_cp_i; count <= ((tail+push) - head_cp_i) mod DEPTH, with a result of 0 mapped to DEPTH.
  - stall_i or empty_o: head held; count <= count + push.
  - otherwise: head <= (head+pop) mod DEPTH; count <= count - pop + push.
- All sums use clog2(DEPTH)+1 bits. Wrap is done by conditional subtract of DEPTH, not masking, so non-power-of-two depths are valid.
- When recover_i and br_recover_i are asserted together, recover_i wins.
- Overflow (count - pop + push > DEPTH) and non-contiguous req_i are illegal. Both are flagged by simulation-only assertions; RTL behaviour is undefined.
- Reset asserted mid-operation discards all in-flight pushes and pops that cycle.

Optional Feature:
Macro: SPEC_FREE_LIST_PARTIAL_ALLOC_EN
- Defined: allocation is per lane. valid[k] = (count > k). empty_o = (popcount(req_i) > count). When empty_o is asserted, no lane pops, so a group is still all-or-nothing, but a group of R requests proceeds whenever count >= R.
- Undefined: the default mode above applies, i.e. a full DISPATCH_W tags must be available.

Decomposition:
- Shared package spec_free_list_pkg:
  - clog2 function.
  - wrap_add(a,b,DEPTH) and wrap_sub functions.
  - popcount function parametrised by width.
- Sub-module free_list_ram: DISPATCH_W combinational read ports, COMMIT_W write ports, reset-time initialisation to NUM_ARCH+i.
- Push compaction (prefix-sum of commit_valid_i to write-port index) lives in the top level.

Test Plan (DEPTH=32, DISPATCH_W=4, COMMIT_W=4, NUM_ARCH=32):
- Reset, then req_i=4'b1111 for 2 cycles -> cycle 0 lanes give tags 32..35 valid; cycle 1 gives 36..39; head_o=8, count_o=24.
- Drain to count=3, req_i=4'b0011 -> default build: empty_o=1, no pop. PARTIAL_ALLOC build: pop 2, count=1.
- commit_valid_i=4'b1010 with tags 5 and 9 at tail=0 -> RAM[0]=5, RAM[1]=9; tail=2; count +2 next cycle.
- Head=30, pop 4 -> lanes read entries 30,31,0,1; head_o=2 (wrap check).
- head_cp_i=10, tail=6, br_recover_i with push=2 -> head=10, count=30. Repeat with tail=10, push=0 -> count=32.
- recover_i and br_recover_i asserted together with push=1, tail=20 -> head=21, count=32, tail=21.
